// File: rtl/led_fade_pwm.sv
// LED fader: PWM comparator against an upstream ramp, with a duty value that
// walks one step at a time toward a target and only changes on period edges.
module led_fade_pwm #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ramp,
  input  logic [7:0] target,
  input  logic [3:0] step_div,
  input  logic       load,
  output logic       busy,
  output logic       fade_done,
  output logic [7:0] duty,
  output logic       pwm_out
);

  typedef enum logic {
    IDLE,
    FADE
  } state_t;

  localparam logic OFF_LVL = ACTIVE_HIGH ? 1'b0 : 1'b1;

  state_t     state;
  logic [7:0] ramp_q;
  logic [7:0] duty_cur;
  logic [7:0] duty_act;
  logic [7:0] tgt_q;
  logic [3:0] div_q;
  logic [3:0] cnt;
  logic       busy_q;
  logic       done_q;
  logic       pwm_q;

  logic       period_start;
  logic       on;
  logic [7:0] duty_nxt;

  // A ramp parked at 0 yields a single period start thanks to ramp_q.
  always_comb begin
    period_start = (ramp == 8'd0) && (ramp_q != 8'd0);
    on           = (ramp < duty_act);
    duty_nxt     = (duty_cur < tgt_q) ? duty_cur + 8'd1
                                      : duty_cur - 8'd1;
  end

  // Comparator side: the applied duty only moves on a period edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ramp_q   <= 8'd0;
      duty_act <= 8'd0;
      pwm_q    <= OFF_LVL;
    end else begin
      ramp_q <= ramp;
      if (period_start) begin
        duty_act <= duty_cur;
      end
      pwm_q <= ACTIVE_HIGH ? on : ~on;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      duty_cur <= 8'd0;
      tgt_q    <= 8'd0;
      div_q    <= 4'd0;
      cnt      <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        tgt_q <= target;
        div_q <= step_div;
        cnt   <= 4'd0;
        if (target != duty_cur) begin
          state  <= FADE;
          busy_q <= 1'b1;
        end else begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= cnt;
          end
          FADE: begin
            if (period_start) begin
              if (cnt == div_q) begin
                cnt      <= 4'd0;
                duty_cur <= duty_nxt;
                if (duty_nxt == tgt_q) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign fade_done = done_q;
  assign duty      = duty_act;
  assign pwm_out   = pwm_q;

endmodule

// File: doc/led_fade_pwm.md
LED_FADE_PWM -- requirements
Module: led_fade_pwm

Interface
REQ-001 Parameter: ACTIVE_HIGH, default 1, output polarity; 1 = pwm_out high during on-time, 0 = pwm_out low during on-time.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 ramp  input  8  free-running ramp from upstream ramp generator, +1 per clk, wraps 255->0.
REQ-005 target  input  8  requested final duty, sampled when load=1.
REQ-006 step_div  input  4  ramp periods per fade step minus 1, sampled when load=1.
REQ-007 load  input  1  one-cycle command strobe, accepted in every cycle reset_n=1.
REQ-008 busy  output  1  high while a fade is in progress.
REQ-009 fade_done  output  1  one-cycle pulse when duty_cur reaches target.
REQ-010 duty  output  8  duty value currently applied to the comparator (duty_act).
REQ-011 pwm_out  output  1  registered PWM output.

Function
REQ-012 ramp_q SHALL register ramp every cycle; period_start = (ramp==0) && (ramp_q!=0).
REQ-013 A ramp held at 0 SHALL produce exactly one period_start.
REQ-014 duty_act SHALL load from duty_cur only in a period_start cycle, so no period sees a mid-period duty change.
REQ-015 on = (ramp < duty_act), unsigned 8-bit; pwm_out SHALL be registered on, inverted when ACTIVE_HIGH=0; latency one clk from ramp.
REQ-016 duty_act=0 SHALL give zero on-cycles per period; duty_act=255 SHALL give 255 of 256.
REQ-017 FSM states: IDLE, FADE; busy=1 exactly in FADE.
REQ-018 On load: tgt_q<-target, div_q<-step_div, divider count<-0; next state FADE if target!=duty_cur, else IDLE.
REQ-019 load with target==duty_cur SHALL pulse fade_done in the next cycle and leave duty_cur unchanged.
REQ-020 load in FADE SHALL retarget immediately (same rules as REQ-018), restarting the divider count; no fade_done for the abandoned target.
REQ-021 In FADE, each period_start SHALL increment the 4-bit divider count; when count==div_q at a period_start, duty_cur SHALL step by 1 toward tgt_q and count<-0.
REQ-022 duty_cur SHALL never overshoot or wrap past tgt_q; no arithmetic wrap at 0 or 255.
REQ-023 When a step makes duty_cur==tgt_q: state<-IDLE, fade_done pulses in the next cycle, busy falls in the same cycle.
REQ-024 load coincident with a step-eligible period_start: load SHALL win; no step in that cycle.
REQ-025 In IDLE, period_starts SHALL NOT change duty_cur or the divider count.
REQ-026 Full fade time = |target-duty_cur| x (step_div+1) ramp periods, +/- one period of phase alignment.

Reset
REQ-027 With reset_n=0 at a clk edge: state=IDLE, duty_cur=0, duty_act=0, tgt_q=0, div_q=0, count=0, ramp_q=0, busy=0, fade_done=0.
REQ-028 pwm_out reset value SHALL be the off level: 0 when ACTIVE_HIGH=1, 1 when ACTIVE_HIGH=0.
REQ-029 Reset during FADE SHALL abort the fade with no fade_done pulse; load in the same cycle as reset SHALL be ignored.

Verification
REQ-030 Static duty: reset, load target=64 step_div=0, wait to done -> steady state 64 high cycles of every 256, duty=64.
REQ-031 Fade up: from 0, load target=3 step_div=1 -> duty 1,2,3 at every 2nd period_start, busy high ~6 periods, one fade_done pulse.
REQ-032 Glitch-free: load target=200 mid-period (ramp=100) with duty 50 step_div=0 -> current period keeps 50 on-cycles; change at period boundary only.
REQ-033 Retarget: fading 0->100, at duty=40 load target=10 -> duty descends 39..10, single fade_done at 10, none for 100.
REQ-034 Limits: target=255 and target=0 -> on-cycles 255 and 0 per period; no wrap; load target==duty -> fade_done next cycle, busy stays 0.
REQ-035 Reset mid-fade at duty=30 -> next cycle duty=0, busy=0, pwm_out off level, fade_done never asserted.
